// File: rtl/elevator_scheduler.sv
// Single-car elevator scheduler: scans in one direction serving every requested
// floor on the way, reverses when that side empties, and holds the door on re-calls.
module elevator_scheduler #(
  parameter int FLOORS        = 8,
  parameter int TRAVEL_CYCLES = 16,
  parameter int DOOR_CYCLES   = 32,
  localparam int FW = (FLOORS > 2) ? $clog2(FLOORS) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [FLOORS-1:0] call_req,
  output logic [FLOORS-1:0] pending,
  output logic [FW-1:0]     current_floor,
  output logic [FW-1:0]     target,
  output logic [1:0]        sim_state,
  output logic              door_open
);

  localparam int TW = (TRAVEL_CYCLES > 1) ? $clog2(TRAVEL_CYCLES) : 1;
  localparam int DW = (DOOR_CYCLES > 1) ? $clog2(DOOR_CYCLES) : 1;
  localparam logic [TW-1:0] TRAVEL_LAST = TW'(TRAVEL_CYCLES - 1);
  localparam logic [DW-1:0] DOOR_LAST   = DW'(DOOR_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE      = 2'b00,
    MOVE_UP   = 2'b01,
    MOVE_DOWN = 2'b10,
    DOOR      = 2'b11
  } state_t;

  state_t            state, state_n, rule_state, move_state;
  logic              dir, dir_n, rule_dir;
  logic              arrived, arrived_n;
  logic [TW-1:0]     travel_cnt, travel_cnt_n;
  logic [DW-1:0]     door_cnt, door_cnt_n;
  logic [FW-1:0]     floor_n, tgt_up, tgt_dn;
  logic [FLOORS-1:0] calls, req, pending_n;
  logic              above, below, here;

  // Calls are invisible while reset is held.
  assign calls = rst ? '0 : call_req;
  assign req   = pending | calls;

  always_comb begin
    above  = 1'b0;
    below  = 1'b0;
    tgt_up = current_floor;
    tgt_dn = current_floor;
    // Descending scan: last hit is the lowest floor above the car.
    for (int i = FLOORS - 1; i >= 0; i--) begin
      if (req[i] && (i > int'(current_floor))) begin
        above  = 1'b1;
        tgt_up = FW'(i);
      end
    end
    for (int i = 0; i < FLOORS; i++) begin
      if (req[i] && (i < int'(current_floor))) begin
        below  = 1'b1;
        tgt_dn = FW'(i);
      end
    end
    here = req[current_floor];
  end

  assign target = dir ? tgt_dn : tgt_up;

  // Common decision: serve here, keep scanning, else reverse, else rest.
  always_comb begin
    rule_state = IDLE;
    rule_dir   = dir;
    if (here) begin
      rule_state = DOOR;
    end else if (above && !dir) begin
      rule_state = MOVE_UP;
    end else if (below && dir) begin
      rule_state = MOVE_DOWN;
    end else if (above) begin
      rule_state = MOVE_UP;
      rule_dir   = 1'b0;
    end else if (below) begin
      rule_state = MOVE_DOWN;
      rule_dir   = 1'b1;
    end
  end

  always_comb begin
    state_n      = state;
    dir_n        = dir;
    arrived_n    = 1'b0;
    travel_cnt_n = travel_cnt;
    door_cnt_n   = door_cnt;
    floor_n      = current_floor;
    move_state   = state;
    case (state)
      IDLE: begin
        state_n      = rule_state;
        dir_n        = rule_dir;
        travel_cnt_n = '0;
        door_cnt_n   = '0;
      end
      MOVE_UP, MOVE_DOWN: begin
        // The decision is only taken in the first cycle at a newly reached floor.
        if (arrived) begin
          move_state = rule_state;
          dir_n      = rule_dir;
        end
        if (move_state == state) begin
          if (travel_cnt == TRAVEL_LAST) begin
            travel_cnt_n = '0;
            arrived_n    = 1'b1;
            floor_n      = (state == MOVE_UP) ? current_floor + FW'(1)
                                              : current_floor - FW'(1);
          end else begin
            travel_cnt_n = travel_cnt + TW'(1);
          end
        end else begin
          state_n      = move_state;
          travel_cnt_n = '0;
          door_cnt_n   = '0;
        end
      end
      DOOR: begin
        if (calls[current_floor]) begin
          door_cnt_n = '0;
        end else if (door_cnt == DOOR_LAST) begin
          state_n      = rule_state;
          dir_n        = rule_dir;
          door_cnt_n   = '0;
          travel_cnt_n = '0;
        end else begin
          door_cnt_n = door_cnt + DW'(1);
        end
      end
      default: state_n = IDLE;
    endcase

    pending_n = req;
    if ((state == DOOR) || (state_n == DOOR)) begin
      pending_n[current_floor] = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      dir           <= 1'b0;
      arrived       <= 1'b0;
      travel_cnt    <= '0;
      door_cnt      <= '0;
      current_floor <= '0;
      pending       <= '0;
    end else begin
      state         <= state_n;
      dir           <= dir_n;
      arrived       <= arrived_n;
      travel_cnt    <= travel_cnt_n;
      door_cnt      <= door_cnt_n;
      current_floor <= floor_n;
      pending       <= pending_n;
    end
  end

  assign sim_state = state;
  assign door_open = (state == DOOR);

endmodule

// File: tb/tb_elevator_scheduler.sv
// Directed bench for elevator_scheduler (8 floors, 4-cycle travel, 6-cycle door).
module tb_elevator_scheduler;

  localparam int FLOORS = 8;
  localparam int FW     = 3;

  logic              clk;
  logic              rst;
  logic [FLOORS-1:0] call_req;
  logic [FLOORS-1:0] pending;
  logic [FW-1:0]     current_floor;
  logic [FW-1:0]     target;
  logic [1:0]        sim_state;
  logic              door_open;

  int vectors;
  int miscompares;
  logic [FW-1:0] exp_q[$];
  logic [FW-1:0] prev_floor;

  elevator_scheduler #(
    .FLOORS(FLOORS),
    .TRAVEL_CYCLES(4),
    .DOOR_CYCLES(6)
  ) dut (
    .clk(clk),
    .rst(rst),
    .call_req(call_req),
    .pending(pending),
    .current_floor(current_floor),
    .target(target),
    .sim_state(sim_state),
    .door_open(door_open)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Car must never wrap across the end floors.
  always @(negedge clk) begin
    if (!rst) begin
      assert (!((prev_floor == 3'd7) && (current_floor == 3'd0)) &&
              !((prev_floor == 3'd0) && (current_floor == 3'd7)))
        else $error("floor wrap from %0d to %0d", prev_floor, current_floor);
    end
    prev_floor = current_floor;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Driver tasks: advance one edge, then sit 1ns after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_call(input logic [FLOORS-1:0] mask);
    call_req = mask;
    step();
    call_req = '0;
  endtask

  task automatic wait_floor(input logic [FW-1:0] f, output int n);
    n = 0;
    do begin
      step();
      n++;
    end while ((current_floor != f) && (n < 200));
    check("floor_reached", current_floor, f);
  endtask

  // Expects the car to be one edge away from opening at a scoreboard floor.
  task automatic door_stop();
    logic [FW-1:0] exp_f;
    step();
    check("door_enter_state", sim_state, 2'b11);
    if (exp_q.size() == 0) begin
      check("stop_queue_empty", 1, 0);
    end else begin
      exp_f = exp_q.pop_front();
      check("stop_floor", current_floor, exp_f);
    end
  endtask

  task automatic wait_close(output int n);
    n = 0;
    while (door_open && (n < 100)) begin
      n++;
      step();
    end
  endtask

  int n;
  int total;

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst         = 1'b1;
    call_req    = '0;
    prev_floor  = '0;
    repeat (3) step();
    rst = 1'b0;

    // Reset state after 10 idle cycles
    repeat (10) step();
    check("rst_state", sim_state, 2'b00);
    check("rst_floor", current_floor, 0);
    check("rst_pending", pending, 8'h00);
    check("rst_door", door_open, 0);
    check("rst_target", target, 0);

    // Call at own floor opens door for 6 cycles
    pulse_call(8'h01);
    check("own_state", sim_state, 2'b11);
    check("own_door", door_open, 1);
    check("own_pending", pending, 8'h00);
    wait_close(n);
    check("own_door_len", n, 6);
    check("own_after_state", sim_state, 2'b00);
    check("own_after_pending", pending, 8'h00);

    // Up to 5, pick up 2 on the way, reverse to 0
    exp_q.push_back(3'd2);
    exp_q.push_back(3'd5);
    exp_q.push_back(3'd0);
    pulse_call(8'h20);
    check("scan_state", sim_state, 2'b01);
    check("scan_target5", target, 5);
    wait_floor(3'd1, n);
    check("scan_lat1", n, 4);
    step();
    call_req = 8'h05;
    #1;
    check("scan_target2", target, 2);
    step();
    call_req = '0;
    check("scan_pending", pending, 8'h25);
    wait_floor(3'd2, n);
    check("scan_lat2", n, 2);
    door_stop();
    check("scan_door2_target", target, 5);
    wait_close(n);
    check("scan_door2_len", n, 6);
    check("scan_resume", sim_state, 2'b01);
    wait_floor(3'd5, n);
    check("scan_lat5", n, 12);
    door_stop();
    check("scan_door5_target", target, 5);
    check("scan_door5_pending", pending, 8'h01);
    wait_close(n);
    check("scan_reverse", sim_state, 2'b10);
    check("scan_target0", target, 0);
    wait_floor(3'd0, n);
    check("scan_lat0", n, 20);
    door_stop();
    wait_close(n);
    check("scan_end_state", sim_state, 2'b00);
    check("scan_end_pending", pending, 8'h00);

    // Floor 0 to 3, one floor every 4 cycles
    exp_q.push_back(3'd3);
    pulse_call(8'h08);
    check("up_state", sim_state, 2'b01);
    for (int f = 1; f <= 3; f++) begin
      wait_floor(FW'(f), n);
      check("up_lat", n, 4);
    end
    check("up_arrive_state", sim_state, 2'b01);
    door_stop();
    wait_close(n);
    check("up_end_pending", pending, 8'h00);
    check("up_end_state", sim_state, 2'b00);

    // Door re-call at floor 4 during the 4th door cycle
    exp_q.push_back(3'd4);
    pulse_call(8'h10);
    wait_floor(3'd4, n);
    check("hold_lat", n, 4);
    door_stop();
    repeat (3) step();
    call_req = 8'h10;
    step();
    call_req = '0;
    check("hold_pending", pending[4], 0);
    check("hold_door", door_open, 1);
    wait_close(n);
    total = 4 + n;
    check("hold_door_len", total, 10);
    check("hold_end_state", sim_state, 2'b00);
    check("hold_end_pending", pending, 8'h00);

    // Asynchronous reset in the middle of a move
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rst2_floor", current_floor, 0);
    pulse_call(8'h80);
    wait_floor(3'd3, n);
    check("mid_lat", n, 12);
    repeat (2) step();
    check("mid_state", sim_state, 2'b01);
    check("mid_pending", pending, 8'h80);
    #3;
    rst = 1'b1;
    #1;
    check("async_state", sim_state, 2'b00);
    check("async_floor", current_floor, 0);
    check("async_pending", pending, 8'h00);
    check("async_door", door_open, 0);
    check("async_target", target, 0);
    step();
    rst = 1'b0;
    repeat (3) step();
    check("post_rst_pending", pending, 8'h00);
    check("post_rst_state", sim_state, 2'b00);
    check("stop_queue_drained", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
